// File: rtl/tick_scheduler_pkg.sv
// Shared types and helpers for the millisecond tick scheduler.
package tick_scheduler_pkg;

  localparam int DEFAULT_N_CH  = 4;
  localparam int DEFAULT_CNT_W = 16;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_BUSY = 1'b1
  } ch_state_t;

  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/tick_scheduler_if.sv
// Client-facing request/grant bundle of the tick scheduler.
interface tick_scheduler_if
  import tick_scheduler_pkg::*;
#(
  parameter int N_CH  = DEFAULT_N_CH,
  parameter int CNT_W = DEFAULT_CNT_W
);
  // req[i] acts as a level valid held until ack[i]; ack[i] is the one-cycle
  // ready/grant, and dur_ms slice i is captured on the edge that raises ack[i].
  logic [N_CH-1:0]       req;
  logic [N_CH*CNT_W-1:0] dur_ms;
  logic [N_CH-1:0]       cancel;
  logic [N_CH-1:0]       ack;
  logic [N_CH-1:0]       busy;
  logic [N_CH-1:0]       done;
  logic                  tick;

  modport master (output req, dur_ms, cancel, input ack, busy, done, tick);
  modport slave  (input req, dur_ms, cancel, output ack, busy, done, tick);

endinterface

// File: rtl/tick_scheduler_tick_gen.sv
// Free-running divider producing a registered one-cycle strobe every DIV clocks.
module tick_gen
  import tick_scheduler_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1000
) (
  input  logic clk_in_50M,
  input  logic reset,
  output logic tick
);
  localparam int DIV   = calc_div(CLK_HZ, TICK_HZ);
  localparam int DIV_W = $clog2(DIV);
  localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] r_cnt;
  logic             r_tick;

  always_ff @(posedge clk_in_50M or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= (r_cnt == LAST);
      r_cnt  <= (r_cnt == LAST) ? '0 : r_cnt + DIV_W'(1);
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/tick_scheduler.sv
// Round-robin granted one-shot delay timers sharing a single tick time base.
module tick_scheduler
  import tick_scheduler_pkg::*;
#(
  parameter int N_CH    = DEFAULT_N_CH,
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1000,
  parameter int CNT_W   = DEFAULT_CNT_W
) (
  input  logic              clk_in_50M,
  input  logic              reset,
  tick_scheduler_if.slave   sl,
  output ch_state_t         o_dbg_state [N_CH]
);
  localparam int PTR_W = $clog2(N_CH);
  localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(N_CH - 1);

  logic             w_tick;
  logic [N_CH-1:0]  w_elig, w_grant, w_busy, w_done;
  logic [N_CH-1:0]  r_ack;
  logic [PTR_W-1:0] r_ptr, w_ptr_nxt, w_cand;
  logic [PTR_W:0]   w_sum;
  logic             w_found;

  tick_gen #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) u_tick_gen (
    .clk_in_50M (clk_in_50M),
    .reset      (reset),
    .tick       (w_tick)
  );

  assign w_elig = sl.req & ~w_busy & ~sl.cancel;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    w_grant   = '0;
    w_ptr_nxt = r_ptr;
    w_found   = 1'b0;
    w_sum     = '0;
    w_cand    = '0;
    for (int k = 1; k <= N_CH; k++) begin
      w_sum = {1'b0, r_ptr} + (PTR_W+1)'(k);
      if (w_sum >= (PTR_W+1)'(N_CH)) w_sum = w_sum - (PTR_W+1)'(N_CH);
      w_cand = w_sum[PTR_W-1:0];
      if (!w_found && w_elig[w_cand]) begin
        w_found         = 1'b1;
        w_grant[w_cand] = 1'b1;
        w_ptr_nxt       = w_cand;
      end
    end
  end

  always_ff @(posedge clk_in_50M or posedge reset) begin
    if (reset) begin
      r_ptr <= PTR_RST;
      r_ack <= '0;
    end else begin
      r_ptr <= w_ptr_nxt;
      r_ack <= w_grant;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    ch_state_t        r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_dur;
    logic             r_done, w_done_nxt;

    assign w_dur = sl.dur_ms[i*CNT_W +: CNT_W];

    always_ff @(posedge clk_in_50M or posedge reset) begin
      if (reset) begin
        r_state <= CH_IDLE;
        r_cnt   <= '0;
        r_done  <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_done  <= w_done_nxt;
      end
    end

    // A grant only reaches an idle channel, so a tick on the grant edge never
    // touches the freshly loaded count; cancel outranks expiry.
    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_done_nxt  = 1'b0;
      case (r_state)
        CH_IDLE: begin
          if (w_grant[i]) begin
            if (w_dur == '0) begin
              w_done_nxt = 1'b1;
            end else begin
              w_state_nxt = CH_BUSY;
              w_cnt_nxt   = w_dur;
            end
          end
        end
        CH_BUSY: begin
          if (sl.cancel[i]) begin
            w_state_nxt = CH_IDLE;
            w_cnt_nxt   = '0;
          end else if (w_tick) begin
            if (r_cnt <= CNT_W'(1)) begin
              w_state_nxt = CH_IDLE;
              w_cnt_nxt   = '0;
              w_done_nxt  = 1'b1;
            end else begin
              w_cnt_nxt = r_cnt - CNT_W'(1);
            end
          end
        end
        default: begin
          w_state_nxt = CH_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end

    assign w_busy[i]      = (r_state == CH_BUSY);
    assign w_done[i]      = r_done;
    assign o_dbg_state[i] = r_state;
  end

  assign sl.ack  = r_ack;
  assign sl.busy = w_busy;
  assign sl.done = w_done;
  assign sl.tick = w_tick;

endmodule

// File: tb/tb_tick_scheduler.sv
// Bench for tick_scheduler: vector table, directed corner cases, random run vs model.
module tb_tick_scheduler;
  import tick_scheduler_pkg::*;

  localparam int N   = 4;
  localparam int W   = 16;
  localparam int DIV = 10;

  logic clk_in_50M = 1'b0;
  logic reset      = 1'b1;
  always #5 clk_in_50M = ~clk_in_50M;

  tick_scheduler_if #(.N_CH(N), .CNT_W(W)) bus();
  ch_state_t dbg_state [N];

  tick_scheduler #(.N_CH(N), .CLK_HZ(10), .TICK_HZ(1), .CNT_W(W)) dut (
    .clk_in_50M  (clk_in_50M),
    .reset       (reset),
    .sl          (bus.slave),
    .o_dbg_state (dbg_state)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: edge count since release, per-channel remaining ticks.
  int         n_edges;
  logic [N-1:0] m_busy, m_ack, m_done;
  logic       m_tick;
  int         m_rem [N];
  int         m_ptr;

  function automatic void model_reset();
    n_edges = 0;
    m_busy  = '0;
    m_ack   = '0;
    m_done  = '0;
    m_tick  = 1'b0;
    m_ptr   = N - 1;
    for (int i = 0; i < N; i++) m_rem[i] = 0;
  endfunction

  function automatic void model_edge();
    logic [N-1:0] busy_before;
    logic         tick_before;
    int           c, d;
    busy_before = m_busy;
    tick_before = m_tick;
    n_edges++;
    m_ack  = '0;
    m_done = '0;
    for (int i = 0; i < N; i++) begin
      if (busy_before[i]) begin
        if (bus.cancel[i]) begin
          m_busy[i] = 1'b0;
          m_rem[i]  = 0;
        end else if (tick_before) begin
          m_rem[i] = m_rem[i] - 1;
          if (m_rem[i] == 0) begin
            m_busy[i] = 1'b0;
            m_done[i] = 1'b1;
          end
        end
      end
    end
    for (int k = 1; k <= N; k++) begin
      c = (m_ptr + k) % N;
      if (bus.req[c] && !busy_before[c] && !bus.cancel[c]) begin
        m_ack[c] = 1'b1;
        m_ptr    = c;
        d        = int'(bus.dur_ms[c*W +: W]);
        if (d == 0) m_done[c] = 1'b1;
        else begin
          m_busy[c] = 1'b1;
          m_rem[c]  = d;
        end
        break;
      end
    end
    m_tick = (n_edges % DIV == 0);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  task automatic set_in(input logic [N-1:0] r, input logic [N-1:0] c, input int d);
    bus.req    = r;
    bus.cancel = c;
    for (int i = 0; i < N; i++) bus.dur_ms[i*W +: W] = W'(d);
  endtask

  task automatic cyc();
    @(posedge clk_in_50M);
    if (reset) model_reset();
    else model_edge();
    #1;
    check("m_ack",  32'(bus.ack),  32'(m_ack));
    check("m_busy", 32'(bus.busy), 32'(m_busy));
    check("m_done", 32'(bus.done), 32'(m_done));
    check("m_tick", 32'(bus.tick), 32'(m_tick));
  endtask

  task automatic do_reset();
    set_in('0, '0, 0);
    reset = 1'b1;
    #1;
    model_reset();
    repeat (3) cyc();
    reset = 1'b0;
  endtask

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] cancel;
    int           dur;
    logic [N-1:0] ack;
    logic [N-1:0] busy;
    logic [N-1:0] done;
    logic         tick;
  } vec_t;

  vec_t         tbl [10];
  logic [N-1:0] rr_exp [4];

  initial begin
    int ticks, done_edge;
    tbl[0] = '{4'b0001, 4'b0000, 5, 4'b0001, 4'b0001, 4'b0000, 1'b0};
    tbl[1] = '{4'b1111, 4'b0000, 5, 4'b0010, 4'b0011, 4'b0000, 1'b0};
    tbl[2] = '{4'b1111, 4'b0000, 5, 4'b0100, 4'b0111, 4'b0000, 1'b0};
    tbl[3] = '{4'b1111, 4'b0000, 5, 4'b1000, 4'b1111, 4'b0000, 1'b0};
    tbl[4] = '{4'b1111, 4'b0000, 5, 4'b0000, 4'b1111, 4'b0000, 1'b0};
    tbl[5] = '{4'b0000, 4'b0101, 5, 4'b0000, 4'b1010, 4'b0000, 1'b0};
    tbl[6] = '{4'b0001, 4'b0000, 5, 4'b0001, 4'b1011, 4'b0000, 1'b0};
    tbl[7] = '{4'b0100, 4'b0100, 5, 4'b0000, 4'b1011, 4'b0000, 1'b0};
    tbl[8] = '{4'b0100, 4'b0000, 0, 4'b0100, 4'b1011, 4'b0100, 1'b0};
    tbl[9] = '{4'b0000, 4'b0000, 5, 4'b0000, 4'b1011, 4'b0000, 1'b1};
    rr_exp = '{4'b1000, 4'b0001, 4'b0010, 4'b0100};

    // Vector table from a fresh reset: RR order, busy block, cancel, dur=0.
    do_reset();
    for (int r = 0; r < 10; r++) begin
      set_in(tbl[r].req, tbl[r].cancel, tbl[r].dur);
      cyc();
      check($sformatf("tbl%0d_ack", r),  32'(bus.ack),  32'(tbl[r].ack));
      check($sformatf("tbl%0d_busy", r), 32'(bus.busy), 32'(tbl[r].busy));
      check($sformatf("tbl%0d_done", r), 32'(bus.done), 32'(tbl[r].done));
      check($sformatf("tbl%0d_tick", r), 32'(bus.tick), 32'(tbl[r].tick));
    end

    // Asynchronous reset mid-count, then tick phase restarts from release.
    set_in('0, '0, 5);
    reset = 1'b1;
    #1;
    check("arst_busy", 32'(bus.busy), 32'(0));
    check("arst_done", 32'(bus.done), 32'(0));
    check("arst_ack",  32'(bus.ack),  32'(0));
    check("arst_tick", 32'(bus.tick), 32'(0));
    model_reset();
    repeat (2) cyc();
    reset = 1'b0;
    for (int e = 1; e <= 30; e++) begin
      cyc();
      check("tick_phase", 32'(bus.tick), 32'(e % DIV == 0));
    end

    // Single timer dur=3 on ch1: latency and tick count.
    do_reset();
    set_in(4'b0010, '0, 3);
    cyc();
    check("lat_ack", 32'(bus.ack), 32'(4'b0010));
    set_in('0, '0, 3);
    ticks     = 0;
    done_edge = -1;
    for (int e = 2; e <= 60; e++) begin
      cyc();
      if (bus.done[1]) begin
        done_edge = e;
        break;
      end
      if (bus.tick) ticks++;
    end
    check("lat_done_edge", 32'(done_edge), 32'(31));
    check("lat_ticks", 32'(ticks), 32'(3));
    check("lat_range", 32'(done_edge - 1 >= 21 && done_edge - 1 <= 31), 32'(1));
    check("lat_busy_clr", 32'(bus.busy[1]), 32'(0));

    // Pointer parked at ch2 by a zero-length grant, then all four request.
    do_reset();
    set_in(4'b0100, '0, 0);
    cyc();
    check("z_ack",  32'(bus.ack),  32'(4'b0100));
    check("z_done", 32'(bus.done), 32'(4'b0100));
    check("z_busy", 32'(bus.busy), 32'(0));
    set_in(4'b1111, '0, 5);
    for (int j = 0; j < 4; j++) begin
      cyc();
      check($sformatf("rr2_%0d", j), 32'(bus.ack), 32'(rr_exp[j]));
    end

    // Cancel on the exact tick where ch0 would expire; idle ch3 cancel blocks grant.
    do_reset();
    set_in(4'b0001, '0, 2);
    cyc();
    check("can_ack", 32'(bus.ack), 32'(4'b0001));
    set_in('0, '0, 2);
    repeat (19) cyc();
    check("can_pre_tick", 32'(bus.tick), 32'(1));
    check("can_pre_busy", 32'(bus.busy[0]), 32'(1));
    set_in(4'b1000, 4'b1001, 2);
    cyc();
    check("can_busy", 32'(bus.busy[0]), 32'(0));
    check("can_done", 32'(bus.done), 32'(0));
    check("can_ack3", 32'(bus.ack), 32'(0));
    set_in('0, '0, 2);
    repeat (12) cyc();

    // ch1 and ch3 with dur=1 in the same tick period expire together.
    do_reset();
    set_in(4'b1010, '0, 1);
    cyc();
    check("sim_ack1", 32'(bus.ack), 32'(4'b0010));
    cyc();
    check("sim_ack3", 32'(bus.ack), 32'(4'b1000));
    set_in('0, '0, 1);
    repeat (8) cyc();
    check("sim_pre_done", 32'(bus.done), 32'(0));
    cyc();
    check("sim_done", 32'(bus.done), 32'(4'b1010));
    check("sim_busy", 32'(bus.busy), 32'(0));

    // Random traffic against the model.
    do_reset();
    for (int t = 0; t < 1500; t++) begin
      bus.req    = N'($urandom_range(0, 15));
      bus.cancel = ($urandom_range(0, 7) == 0) ? N'($urandom_range(0, 15)) : '0;
      for (int i = 0; i < N; i++) bus.dur_ms[i*W +: W] = W'($urandom_range(0, 4));
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
